// File: rtl/sim_result_port_if.sv
// Data-bus interface for sim_result_port: a single-cycle write/read strobe bus.
// The CPU-side agent uses the master modport; the responder uses the slave modport.
interface sim_result_port_if;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_we, mem_re, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata
    );

    modport slave (
        input  mem_we, mem_re, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata
    );
endinterface

// File: rtl/sim_result_port.sv
// Memory-mapped test-status responder: tohost-style verdict FSM, RUN cycle counter, watchdog.
// Optional signature FIFO at offset 0x10 is built only when SIM_RESULT_SIG_EN is defined.
module sim_result_port #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_2000,
    parameter int          TIMEOUT_CYCLES = 768,
    parameter int          SIG_DEPTH      = 16
) (
    input  logic              clk,
    input  logic              rst,
    sim_result_port_if.slave  bus,
    output logic              test_done,
    output logic              test_pass,
    output logic              test_fail,
    output logic              test_tmo,
    output logic [31:0]       test_num,
    output logic [31:0]       cycle_cnt
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PASS,
        ST_FAIL,
        ST_TMO
    } state_t;

    localparam logic [2:0]  OFF_TOHOST  = 3'd0;
    localparam logic [2:0]  OFF_TESTNUM = 3'd1;
    localparam logic [2:0]  OFF_CYCLE   = 3'd2;
    localparam logic [2:0]  OFF_STATUS  = 3'd3;
    localparam logic [2:0]  OFF_SIGDATA = 3'd4;
    localparam logic [31:0] TMO_LAST    = 32'(TIMEOUT_CYCLES - 1);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    state_t      state, state_nxt;
    logic        hit_p0;
    logic [2:0]  off_p0;
    logic        wr_p0;
    logic        rd_p0;
    logic        tohost_wr_p0;
    logic        verdict_p0;
    logic        sig_ovf;
    logic [31:0] sig_rdata_p0;
    logic [31:0] reg_rdata_p0;
    logic [31:0] rdata_p1;
    logic        unused_addr_lsb;

    // Stage p0: address decode of the current bus access
    assign hit_p0          = (bus.mem_addr[31:5] == BASE_ADDR[31:5]);
    assign off_p0          = bus.mem_addr[4:2];
    assign wr_p0           = bus.mem_we && hit_p0 && (bus.mem_wstrb == 4'hF);
    assign rd_p0           = bus.mem_re && hit_p0;
    assign tohost_wr_p0    = wr_p0 && (off_p0 == OFF_TOHOST) && (state == ST_RUN);
    assign verdict_p0      = tohost_wr_p0 && bus.mem_wdata[0];
    assign unused_addr_lsb = ^bus.mem_addr[1:0];

    // A verdict write outranks the watchdog firing in the same cycle
    always_comb begin
        state_nxt = state;
        if (state == ST_RUN) begin
            if (verdict_p0) begin
                state_nxt = (bus.mem_wdata == 32'd1) ? ST_PASS : ST_FAIL;
            end else if (cycle_cnt == TMO_LAST) begin
                state_nxt = ST_TMO;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            cycle_cnt <= '0;
            test_num  <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_RUN) begin
                cycle_cnt <= sat_inc(cycle_cnt);
            end
            if ((state == ST_RUN) && wr_p0 && (off_p0 == OFF_TESTNUM)) begin
                test_num <= bus.mem_wdata;
            end else if (verdict_p0 && (bus.mem_wdata != 32'd1)) begin
                test_num <= {1'b0, bus.mem_wdata[31:1]};
            end
        end
    end

    assign test_done = (state != ST_RUN);
    assign test_pass = (state == ST_PASS);
    assign test_fail = (state == ST_FAIL);
    assign test_tmo  = (state == ST_TMO);

`ifdef SIM_RESULT_SIG_EN
    localparam int SIG_AW = $clog2(SIG_DEPTH);

    logic [31:0]     sig_mem [SIG_DEPTH];
    logic [SIG_AW:0] sig_wptr;
    logic [SIG_AW:0] sig_rptr;
    logic            sig_empty;
    logic            sig_full;
    logic            sig_push;
    logic            sig_pop;

    // Extra pointer bit separates full from empty when the index bits match
    assign sig_empty    = (sig_wptr == sig_rptr);
    assign sig_full     = (sig_wptr[SIG_AW] != sig_rptr[SIG_AW]) &&
                          (sig_wptr[SIG_AW-1:0] == sig_rptr[SIG_AW-1:0]);
    assign sig_push     = wr_p0 && (off_p0 == OFF_SIGDATA);
    assign sig_pop      = rd_p0 && (off_p0 == OFF_SIGDATA) && !sig_empty;
    assign sig_rdata_p0 = sig_empty ? 32'd0 : sig_mem[sig_rptr[SIG_AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_wptr <= '0;
            sig_rptr <= '0;
            sig_ovf  <= 1'b0;
        end else begin
            if (sig_pop) begin
                sig_rptr <= sig_rptr + 1'b1;
            end
            if (sig_push) begin
                if (sig_full) begin
                    sig_ovf <= 1'b1;
                end else begin
                    sig_wptr <= sig_wptr + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sig_push && !sig_full) begin
            sig_mem[sig_wptr[SIG_AW-1:0]] <= bus.mem_wdata;
        end
    end
`else
    localparam int unused_sig_depth = SIG_DEPTH;

    assign sig_ovf      = 1'b0;
    assign sig_rdata_p0 = 32'd0;
`endif

    always_comb begin
        reg_rdata_p0 = 32'd0;
        case (off_p0)
            OFF_CYCLE:   reg_rdata_p0 = cycle_cnt;
            OFF_STATUS:  reg_rdata_p0 = {27'd0, sig_ovf, test_tmo, test_fail, test_pass, test_done};
            OFF_SIGDATA: reg_rdata_p0 = sig_rdata_p0;
            default:     reg_rdata_p0 = 32'd0;
        endcase
    end

    // Stage p1: registered read data, zero unless the previous cycle was a hit read
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_p1 <= '0;
        end else begin
            rdata_p1 <= rd_p0 ? reg_rdata_p0 : 32'd0;
        end
    end

    assign bus.mem_rdata = rdata_p1;

endmodule

// File: tb/tb_sim_result_port.sv
// Directed bench for sim_result_port: expected read data is queued when a read is issued
// and compared when the registered response appears; status outputs are checked directly.
module tb_sim_result_port;

    localparam logic [31:0] BASE = 32'h0000_2000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        test_done;
    logic        test_pass;
    logic        test_fail;
    logic        test_tmo;
    logic [31:0] test_num;
    logic [31:0] cycle_cnt;

    int          total = 0;
    int          bad   = 0;
    int          m_cnt = 0;
    logic        m_run = 1'b0;
    logic [31:0] exp_q [$];

    sim_result_port_if bus_if ();

    sim_result_port #(
        .BASE_ADDR      (BASE),
        .TIMEOUT_CYCLES (768),
        .SIG_DEPTH      (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .test_done (test_done),
        .test_pass (test_pass),
        .test_fail (test_fail),
        .test_tmo  (test_tmo),
        .test_num  (test_num),
        .cycle_cnt (cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; m_cnt tracks how many RUN edges the block has seen
    task automatic step();
        @(posedge clk);
        if (!rst && m_run) m_cnt++;
        #1;
    endtask

    task automatic bus_idle();
        bus_if.mem_we    = 1'b0;
        bus_if.mem_re    = 1'b0;
        bus_if.mem_addr  = 32'd0;
        bus_if.mem_wdata = 32'd0;
        bus_if.mem_wstrb = 4'h0;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] data, input logic [3:0] strb);
        bus_if.mem_we    = 1'b1;
        bus_if.mem_addr  = BASE + off;
        bus_if.mem_wdata = data;
        bus_if.mem_wstrb = strb;
        step();
        bus_idle();
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] e;
        bus_if.mem_re   = 1'b1;
        bus_if.mem_addr = addr;
        exp_q.push_back(exp);
        step();
        bus_idle();
        e = exp_q.pop_front();
        check(tag, bus_if.mem_rdata, e);
    endtask

    task automatic do_reset();
        bus_idle();
        rst   = 1'b1;
        m_run = 1'b0;
        repeat (4) step();
        rst   = 1'b0;
        m_cnt = 0;
        m_run = 1'b1;
    endtask

    initial begin
        bus_idle();

        // T1: pass verdict, counter freezes
        do_reset();
        check("rst_done", {31'd0, test_done}, 32'd0);
        check("rst_pass", {31'd0, test_pass}, 32'd0);
        check("rst_fail", {31'd0, test_fail}, 32'd0);
        check("rst_tmo", {31'd0, test_tmo}, 32'd0);
        check("rst_num", test_num, 32'd0);
        check("rst_cnt", cycle_cnt, 32'd0);
        check("rst_rdata", bus_if.mem_rdata, 32'd0);
        repeat (10) step();
        check("t1_pre_pass", {31'd0, test_pass}, 32'd0);
        wr(32'h00, 32'd1, 4'hF);
        m_run = 1'b0;
        check("t1_pass", {31'd0, test_pass}, 32'd1);
        check("t1_done", {31'd0, test_done}, 32'd1);
        check("t1_fail", {31'd0, test_fail}, 32'd0);
        check("t1_tmo", {31'd0, test_tmo}, 32'd0);
        check("t1_cnt", cycle_cnt, 32'd11);
        repeat (3) step();
        check("t1_cnt_frozen", cycle_cnt, 32'd11);
        rd("t1_status", BASE + 32'h0C, 32'h0000_0003);
        rd("t1_cycle", BASE + 32'h08, 32'd11);
        step();
        check("t1_rdata_idle", bus_if.mem_rdata, 32'd0);

        // T2: fail verdict with test number, later writes ignored
        do_reset();
        wr(32'h04, 32'd5, 4'hF);
        check("t2_num_wr", test_num, 32'd5);
        wr(32'h00, 32'h0000_000B, 4'hF);
        m_run = 1'b0;
        check("t2_fail", {31'd0, test_fail}, 32'd1);
        check("t2_num", test_num, 32'd5);
        wr(32'h00, 32'd1, 4'hF);
        check("t2_no_pass", {31'd0, test_pass}, 32'd0);
        check("t2_still_fail", {31'd0, test_fail}, 32'd1);
        wr(32'h04, 32'd9, 4'hF);
        check("t2_num_locked", test_num, 32'd5);
        rd("t2_status", BASE + 32'h0C, 32'h0000_0005);

        // T2b: odd verdict derives test_num from the TOHOST value
        do_reset();
        wr(32'h00, 32'h0000_0027, 4'hF);
        m_run = 1'b0;
        check("t2b_num", test_num, 32'h0000_0013);

        // T3: watchdog fires after exactly 768 RUN cycles
        do_reset();
        repeat (767) step();
        check("t3_pre_tmo", {31'd0, test_tmo}, 32'd0);
        check("t3_pre_cnt", cycle_cnt, 32'd767);
        step();
        m_run = 1'b0;
        check("t3_tmo", {31'd0, test_tmo}, 32'd1);
        check("t3_done", {31'd0, test_done}, 32'd1);
        check("t3_cnt", cycle_cnt, 32'd768);
        rd("t3_status", BASE + 32'h0C, 32'h0000_0009);
        repeat (5) step();
        check("t3_cnt_frozen", cycle_cnt, 32'd768);

        // T4: verdict on the last watchdog cycle wins
        do_reset();
        repeat (767) step();
        wr(32'h00, 32'd1, 4'hF);
        m_run = 1'b0;
        check("t4_pass", {31'd0, test_pass}, 32'd1);
        check("t4_tmo", {31'd0, test_tmo}, 32'd0);
        check("t4_cnt", cycle_cnt, 32'd768);

        // T5: partial strobe and even value ignored, unmapped and off-base reads return 0
        do_reset();
        wr(32'h00, 32'd1, 4'h1);
        check("t5_strb_done", {31'd0, test_done}, 32'd0);
        wr(32'h00, 32'd2, 4'hF);
        check("t5_even_done", {31'd0, test_done}, 32'd0);
        rd("t5_rd_1c", BASE + 32'h1C, 32'd0);
        rd("t5_rd_offbase", BASE + 32'h28, 32'd0);
        rd("t5_rd_cycle", BASE + 32'h08, 32'(m_cnt));
        rd("t5_status_run", BASE + 32'h0C, 32'd0);
        check("t5_num", test_num, 32'd0);

`ifdef SIM_RESULT_SIG_EN
        // T6: signature FIFO overflow and drain
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            wr(32'h10, 32'(i), 4'hF);
        end
        rd("t6_status_ovf", BASE + 32'h0C, 32'h0000_0010);
        for (int i = 1; i <= 16; i++) begin
            rd("t6_pop", BASE + 32'h10, 32'(i));
        end
        rd("t6_pop_empty", BASE + 32'h10, 32'd0);
`endif

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
